if_fetch_unit: RTL and testbench

Instruction fetch stage directly upstream of the control unit (cu). It holds the PC, issues word requests to instruction memory over a valid/ready channel, and buffers returned words in a small FIFO. It presents each instruction with its PC to decode over a valid/ready handshake. Redirects from branch/jump resolution flush buffered and in-flight fetches.

---
 rtl/if_fetch_unit.sv | 136 +++++++++++++
 tb/tb_if_fetch_unit.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch stage: PC, credit-limited imem requests, instruction buffer
module if_fetch_unit #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] instr_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic {S_BOOT = 1'b0, S_RUN = 1'b1} state_t;

  state_t          state_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   iq_cnt_q, iq_cnt_d;
  logic [PW-1:0]   pcq_rd_q, pcq_rd_d, pcq_wr_q, pcq_wr_d;
  logic [PW-1:0]   iq_rd_q, iq_rd_d, iq_wr_q, iq_wr_d;

  // PCs of in-flight requests, and the buffered {word, pc} pairs
  logic [XLEN-1:0] pcq_mem [FIFO_DEPTH];
  logic [XLEN-1:0] iq_data [FIFO_DEPTH];
  logic [XLEN-1:0] iq_pc   [FIFO_DEPTH];

  logic credit_ok, req_fire, resp_keep, pop;
  logic unused_redirect_lo;

  // the low redirect bits are architecturally ignored
  assign unused_redirect_lo = ^redirect_pc[1:0];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // every in-flight request reserves a buffer slot, so the buffer can never overflow
  assign credit_ok      = ({1'b0, outst_q} + {1'b0, iq_cnt_q}) < SW'(FIFO_DEPTH);
  assign imem_req_valid = (state_q == S_RUN) && !redirect_valid && credit_ok;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign resp_keep      = imem_resp_valid && (drop_q == '0) && !redirect_valid;

  assign instr_valid = (iq_cnt_q != '0);
  assign pop         = instr_valid && instr_ready;
  assign instruction = instr_valid ? iq_data[iq_rd_q] : '0;
  assign instr_pc    = instr_valid ? iq_pc[iq_rd_q]   : '0;

  // next-state for PC, credit counters and both queue pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (req_fire) begin
      fetch_pc_d = fetch_pc_q + XLEN'(4);
    end

    outst_d = outst_q + CW'(req_fire) - CW'(imem_resp_valid);

    // on redirect, everything still pending after this cycle is stale
    drop_d = drop_q;
    if (redirect_valid) begin
      drop_d = outst_d;
    end else if (imem_resp_valid && (drop_q != '0)) begin
      drop_d = drop_q - 1'b1;
    end

    pcq_wr_d = req_fire        ? ptr_inc(pcq_wr_q) : pcq_wr_q;
    pcq_rd_d = imem_resp_valid ? ptr_inc(pcq_rd_q) : pcq_rd_q;

    // a same-cycle pop is honoured first, then the flush wipes the rest
    if (redirect_valid) begin
      iq_rd_d  = '0;
      iq_wr_d  = '0;
      iq_cnt_d = '0;
    end else begin
      iq_rd_d  = pop       ? ptr_inc(iq_rd_q) : iq_rd_q;
      iq_wr_d  = resp_keep ? ptr_inc(iq_wr_q) : iq_wr_q;
      iq_cnt_d = iq_cnt_q + CW'(resp_keep) - CW'(pop);
    end
  end

  // FSM and control registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_BOOT;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      drop_q     <= '0;
      iq_cnt_q   <= '0;
      pcq_rd_q   <= '0;
      pcq_wr_q   <= '0;
      iq_rd_q    <= '0;
      iq_wr_q    <= '0;
    end else begin
      case (state_q)
        S_BOOT:  state_q <= S_RUN;
        default: state_q <= S_RUN;
      endcase
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      iq_cnt_q   <= iq_cnt_d;
      pcq_rd_q   <= pcq_rd_d;
      pcq_wr_q   <= pcq_wr_d;
      iq_rd_q    <= iq_rd_d;
      iq_wr_q    <= iq_wr_d;
    end
  end

  // queue storage; contents are only meaningful under the pointers, so no reset
  always_ff @(posedge clk) begin
    if (req_fire) begin
      pcq_mem[pcq_wr_q] <= fetch_pc_q;
    end
    if (resp_keep) begin
      iq_data[iq_wr_q] <= imem_resp_data;
      iq_pc[iq_wr_q]   <= pcq_mem[pcq_rd_q];
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized self-checking bench for if_fetch_unit
module tb_if_fetch_unit;
  localparam int          DEPTH  = 2;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        instr_valid, instr_ready = 1'b0;
  logic [31:0] instruction, instr_pc;

  if_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instruction(instruction), .instr_pc(instr_pc)
  );

  always #5 clk = ~clk;

  // memory-side request: live=0 once a redirect has made its response stale
  typedef struct { logic [31:0] addr; logic [31:0] data; int due; bit live; } mreq_t;
  // expected decode stream: accepted, still-valid fetches in program order
  typedef struct { logic [31:0] pc; logic [31:0] data; bit ret; } ent_t;

  mreq_t       mem_q[$];
  ent_t        exp_q[$];
  logic [31:0] exp_pc;
  bit          boot, post_rst;
  int          cyc, rdy_pct, mrdy_pct, lat_min, lat_max, delivered;
  int          n_checks, n_errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic rv, input logic [31:0] rpc);
    mreq_t m;
    ent_t  e;
    int    nbuf;
    bit    exp_rv, exp_iv;
    @(posedge clk);
    #1;
    rst            = r;
    redirect_valid = rv;
    redirect_pc    = rpc;
    instr_ready    = ($urandom_range(99) < rdy_pct);
    imem_req_ready = ($urandom_range(99) < mrdy_pct);
    imem_resp_valid = 1'b0;
    imem_resp_data  = $urandom;
    if (!r && mem_q.size() > 0) begin
      if (mem_q[0].due <= cyc) begin
        imem_resp_valid = 1'b1;
        if (mem_q[0].live) imem_resp_data = mem_q[0].data;
      end
    end
    #1;
    if (r) begin
      mem_q.delete();
      exp_q.delete();
      exp_pc   = RST_PC;
      boot     = 1'b1;
      post_rst = 1'b1;
    end else begin
      if (post_rst) begin
        check("rst_instr_valid", instr_valid, 0);
        check("rst_instruction", instruction, 0);
        check("rst_instr_pc", instr_pc, 0);
        check("rst_req_addr", imem_req_addr, RST_PC);
        post_rst = 1'b0;
      end
      nbuf = 0;
      foreach (exp_q[i]) if (exp_q[i].ret) nbuf++;
      exp_rv = !boot && !rv && (mem_q.size() + nbuf < DEPTH);
      check("req_valid", imem_req_valid, exp_rv);
      if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
      exp_iv = (exp_q.size() > 0) && exp_q[0].ret;
      check("instr_valid", instr_valid, exp_iv);
      if (instr_valid && exp_iv) begin
        check("instr_pc", instr_pc, exp_q[0].pc);
        check("instruction", instruction, exp_q[0].data);
      end
      if (instr_valid && instr_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        delivered++;
      end
      if (imem_resp_valid) begin
        m = mem_q.pop_front();
        if (m.live) begin
          for (int i = 0; i < exp_q.size(); i++) begin
            if (!exp_q[i].ret) begin
              exp_q[i].ret = 1'b1;
              break;
            end
          end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        m.addr = exp_pc;
        m.data = $urandom;
        m.live = 1'b1;
        m.due  = cyc + int'($urandom_range(lat_max, lat_min));
        if (mem_q.size() > 0 && m.due <= mem_q[$].due) m.due = mem_q[$].due + 1;
        mem_q.push_back(m);
        e.pc = exp_pc; e.data = m.data; e.ret = 1'b0;
        exp_q.push_back(e);
        exp_pc = exp_pc + 32'd4;
        nbuf = 0;
        foreach (exp_q[i]) if (exp_q[i].ret) nbuf++;
        check("credit", (mem_q.size() + nbuf <= DEPTH), 1);
      end
      if (rv) begin
        foreach (mem_q[i]) mem_q[i].live = 1'b0;
        exp_q.delete();
        exp_pc = {rpc[31:2], 2'b00};
      end
      boot = 1'b0;
    end
    cyc++;
  endtask

  initial begin
    logic        r, rv;
    logic [31:0] rpc;
    n_checks = 0; n_errors = 0; cyc = 0; delivered = 0;
    rdy_pct = 100; mrdy_pct = 100; lat_min = 1; lat_max = 1;
    exp_pc = RST_PC; boot = 1'b1; post_rst = 1'b1;

    step(1, 0, 0);
    step(1, 0, 0);
    // single-cycle memory, decode always ready
    repeat (20) step(0, 0, 0);
    // decode stalls: buffer fills, requests stop, head held
    rdy_pct = 0;
    repeat (10) step(0, 0, 0);
    rdy_pct = 100;
    repeat (10) step(0, 0, 0);
    // 3-cycle memory, redirect with two fetches in flight
    lat_min = 3; lat_max = 3;
    repeat (8) step(0, 0, 0);
    step(0, 1, 32'h0000_0103);
    repeat (15) step(0, 0, 0);
    // PC wrap across the top of the address space
    step(0, 1, 32'hFFFF_FFF8);
    repeat (15) step(0, 0, 0);
    // reset with work in flight and buffered
    rdy_pct = 0;
    repeat (6) step(0, 0, 0);
    step(1, 0, 0);
    rdy_pct = 100;
    repeat (15) step(0, 0, 0);
    // randomized traffic
    lat_min = 1;
    for (int k = 0; k < 4000; k++) begin
      if (k % 200 == 0) begin
        rdy_pct  = $urandom_range(100, 20);
        mrdy_pct = $urandom_range(100, 30);
        lat_max  = $urandom_range(4, 1);
      end
      r   = ($urandom_range(999) == 0);
      rv  = !r && ($urandom_range(39) == 0);
      rpc = $urandom;
      step(r, rv, rpc);
    end
    check("progress", (delivered > 200), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
